// File: rtl/irq_sequencer.sv
// irq_sequencer: takes pending interrupts at instruction boundaries, acks the
// intc, redirects the PC to the ISR and back on eret, keeps per-source
// service counters, and exposes a small register window.
module irq_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0F00, // must be 32-byte aligned
  parameter int          CNT_W     = 16             // service counter width, <= 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IRQ,
  input  logic [31:0] isr_addr,
  input  logic [1:0]  priority_select,
  input  logic        retire,
  input  logic [31:0] pc_next,
  input  logic        eret,
  input  logic [31:0] input_addr,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  output logic        IACK,
  output logic        pc_redirect,
  output logic [31:0] redirect_addr,
  output logic [31:0] read_data,
  output logic        in_isr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    SERVICE = 2'd2,
    RETURN  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               ie_q;
  logic [31:0]        epc_q, vec_q;
  logic [1:0]         id_q;
  logic [CNT_W-1:0]   cnt_q [4];
  logic               take;

  // Register window decode: word offsets 0..7 inside a 32-byte window.
  logic       in_win;
  logic [2:0] widx;
  logic       wr_ctrl;
  logic [3:0] wr_cnt;
  logic       unused_wdata;

  assign in_win       = (input_addr[31:5] == BASE_ADDR[31:5]) && (input_addr[1:0] == 2'b00);
  assign widx         = input_addr[4:2];
  assign wr_ctrl      = write_enable && in_win && (widx == 3'd0);
  assign unused_wdata = ^write_data[31:1];

  always_comb begin
    for (int k = 0; k < 4; k++)
      wr_cnt[k] = write_enable && in_win && (widx == 3'(4 + k));
  end

  assign in_isr = (state_q != IDLE);

  // Next-state and sequencing outputs; only IDLE looks at IRQ, so nesting
  // and re-taking the still-high IRQ during ACK are impossible.
  always_comb begin
    state_d       = state_q;
    take          = 1'b0;
    IACK          = 1'b0;
    pc_redirect   = 1'b0;
    redirect_addr = 32'd0;
    unique case (state_q)
      IDLE: begin
        if (retire && IRQ && ie_q) begin
          take    = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        IACK          = 1'b1;
        pc_redirect   = 1'b1;
        redirect_addr = vec_q;
        state_d       = SERVICE;
      end
      SERVICE: begin
        if (eret) state_d = RETURN;
      end
      RETURN: begin
        pc_redirect   = 1'b1;
        redirect_addr = epc_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, IE, and the context latched at the take decision.
  // The take above reads ie_q, so a same-cycle CTRL write only affects later takes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ie_q    <= 1'b0;
      epc_q   <= 32'd0;
      vec_q   <= 32'd0;
      id_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      if (wr_ctrl) ie_q <= write_data[0];
      if (take) begin
        vec_q <= isr_addr;
        id_q  <= priority_select;
        epc_q <= pc_next;
      end
    end
  end

  // Per-source service counters: clear then increment, so a clear that
  // coincides with the ACK increment leaves 1. Wraps naturally.
  for (genvar k = 0; k < 4; k++) begin : g_cnt
    logic [CNT_W-1:0] cnt_d;
    always_comb begin
      cnt_d = wr_cnt[k] ? '0 : cnt_q[k];
      if (state_q == ACK && id_q == 2'(k)) cnt_d = cnt_d + 1'b1;
    end
    always_ff @(posedge clk) begin
      if (rst) cnt_q[k] <= '0;
      else     cnt_q[k] <= cnt_d;
    end
  end

  // Combinational register read; unmapped offsets and out-of-window read 0.
  always_comb begin
    read_data = 32'd0;
    if (in_win) begin
      case (widx)
        3'd0: read_data[0]   = ie_q;
        3'd1: read_data      = epc_q;
        3'd2: read_data[4:0] = {state_q, id_q, in_isr};
        3'd4, 3'd5, 3'd6, 3'd7: read_data[CNT_W-1:0] = cnt_q[widx[1:0]];
        default: read_data = 32'd0;
      endcase
    end
  end

endmodule

// File: doc/irq_sequencer.md
# irq_sequencer

CPU-side companion to the 4-source interrupt controller (`intc`). It decides when a pending `IRQ` is taken, which is only at an instruction boundary while interrupts are enabled and none is in service. When it takes one, it latches the ISR vector, pulses `IACK` for one cycle, redirects the PC and saves the return address in EPC. It also sequences the return on `eret` and keeps per-source service counters. A small memory-mapped register window is provided for software control.

## Interface
- `BASE_ADDR`, default 32'h0000_0F00: base byte address of the register window.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `IRQ`  in  1  pending-interrupt flag from the intc.
- `isr_addr`  in  32  ISR vector from the intc.
- `priority_select`  in  2  id of the source the intc currently selects.
- `retire`  in  1  an instruction retires this cycle (instruction boundary).
- `pc_next`  in  32  address of the next sequential instruction after the retiring one.
- `eret`  in  1  return-from-interrupt instruction retires this cycle.
- `input_addr`  in  32  bus address.
- `write_data`  in  32  bus write data.
- `write_enable`  in  1  bus write strobe.
- `IACK`  out  1  one-cycle acknowledge to the intc.
- `pc_redirect`  out  1  one-cycle PC override strobe.
- `redirect_addr`  out  32  target PC, valid while `pc_redirect`=1.
- `read_data`  out  32  combinational register read data; 0 when the address is outside the window.
- `in_isr`  out  1  an interrupt is in service.

## Operation
- The FSM has four states: IDLE, ACK, SERVICE, RETURN.
- IDLE → ACK requires `retire & IRQ & IE` in the same cycle. On that edge the block latches:
  - `vec` ← `isr_addr`
  - `id` ← `priority_select`
  - `EPC` ← `pc_next`
- ACK lasts exactly one cycle and drives:
  - `IACK`=1
  - `pc_redirect`=1
  - `redirect_addr`=`vec`
  - Next state is SERVICE, and `count[id]` increments.
- SERVICE holds `in_isr`=1 and ignores `IRQ`. No nesting is allowed.
  - `eret` → RETURN.
- RETURN lasts one cycle: `pc_redirect`=1, `redirect_addr`=`EPC`, then IDLE.
- `eret` outside SERVICE is ignored: no redirect, no state change.
- Register map (byte offsets from `BASE_ADDR`; word access only):
  - 0x00 CTRL: bit0 = IE, read/write, reset 0.
  - 0x04 EPC: read-only.
  - 0x08 STATUS: read-only; bit0 = `in_isr`, bits[2:1] = `id`, bits[4:3] = FSM state (IDLE=0, ACK=1, SERVICE=2, RETURN=3).
  - 0x10/0x14/0x18/0x1C: COUNT0..3, 16 bits zero-extended. A write of any value clears the counter.
- Counters wrap from 0xFFFF to 0x0000.
- Clearing a counter in the same cycle it increments leaves it at 1.
- Writes to read-only or unmapped offsets are ignored.
- Clearing IE while in ACK, SERVICE or RETURN does not abort the sequence. It only blocks the next take in IDLE.

## Timing
- Reset values:
  - State = IDLE.
  - IE, EPC, `vec`, `id` and all counters = 0.
  - `IACK`, `pc_redirect`, `redirect_addr` and `in_isr` = 0.
- `rst` mid-sequence (ACK, SERVICE or RETURN) returns to IDLE on that edge; no `IACK` or redirect is issued afterwards.
- Take latency: decision at edge E (retire cycle). `IACK` and `pc_redirect` are high in cycle E+1. The intc clears the source at the end of E+1, so `IRQ` may still be high in E+1; the FSM is already past IDLE and does not re-take it.
- `priority_select` and `isr_addr` changing after E have no effect; the latched `vec`/`id` are used.
- `in_isr` = 1 from cycle E+1 through the RETURN cycle inclusive.
- Return latency: `eret` at edge R gives `pc_redirect` with `EPC` in cycle R+1 and IDLE in R+2.
- The earliest re-take is the first `retire` at or after R+2.
- `IRQ` asserted without `retire` waits in IDLE indefinitely.
- `IRQ` & `retire` & IE=0: no take, no `IACK`.
- Bus write to CTRL in the same cycle as a take decision: the take uses the old IE.

## Test plan
- Take and return:
  - Stimulus: IE=1; `IRQ`=1, `isr_addr`=0x200, `priority_select`=2, `retire`=1, `pc_next`=0x44.
  - Required response: next cycle `IACK`=1, `pc_redirect`=1, `redirect_addr`=0x200; EPC reads 0x44; COUNT2=1. Later `eret` gives `redirect_addr`=0x44 one cycle after.
- Gating: IE=0, or `retire`=0, with `IRQ`=1 for 10 cycles → `IACK` and `pc_redirect` stay 0 throughout; state stays IDLE.
- No nesting: in SERVICE, assert a new `IRQ` with `retire` pulses → no `IACK`. After `eret` and the RETURN cycle, the first `retire` takes the new interrupt.
- Latching: change `isr_addr` to 0x300 in cycle E+1 → `redirect_addr` is still the value sampled at E.
- Counters:
  - Preload COUNT0 to 0xFFFF by 65535 takes → the next take makes it 0x0000.
  - A write to offset 0x10 coincident with an increment → COUNT0 = 1.
- Reset mid-service: assert `rst` during SERVICE → `in_isr`=0, IE=0, counters=0, no redirect on a subsequent `eret`.
